// File: rtl/int_square_calculator.sv
// int_square_calculator: multi-cycle unsigned squarer that sums the first X odd numbers.
// Start/done four-phase handshake; no multiplier in the datapath.
module int_square_calculator #(
    parameter int W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           S,
    input  logic [W-1:0]   X,
    output logic [2*W-1:0] Sq,
    output logic           Done,
    output logic           Busy,
    output logic [1:0]     State
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ACC  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]     state;
    logic [1:0]     next;
    logic [W-1:0]   cnt;
    logic [W:0]     odd;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] sum;
    logic           last;

    assign sum  = acc + (2*W)'(odd);
    assign last = cnt == W'(1);

    always_ff @(posedge Clk) begin
        if (!Reset)
            state <= IDLE;
        else
            state <= next;
    end

    // Code 11 falls through to IDLE.
    always_comb begin
        next = IDLE;
        next = (state == IDLE) ? (S ? ((X == '0) ? DONE : ACC) : IDLE) :
               (state == ACC)  ? (last ? DONE : ACC) :
               (state == DONE) ? (S ? DONE : IDLE) : IDLE;
    end

    always_comb begin
        Busy  = state == ACC;
        Done  = state == DONE;
        State = state;
    end

    // Sq is written only on completion or reset, never with a partial sum.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt <= '0;
            odd <= (W+1)'(1);
            acc <= '0;
            Sq  <= '0;
        end else if (state == IDLE && S) begin
            if (X != '0) begin
                cnt <= X;
                odd <= (W+1)'(1);
                acc <= '0;
            end else begin
                Sq <= '0;
            end
        end else if (state == ACC) begin
            acc <= sum;
            odd <= odd + (W+1)'(2);
            cnt <= cnt - W'(1);
            if (last)
                Sq <= sum;
        end
    end
endmodule

// File: tb/tb_int_square_calculator.sv
// tb_int_square_calculator: randomized and directed checks of the squarer against X*X
// and the handshake timeline (start edge, X busy cycles, Done after edge k+X).
module tb_int_square_calculator;
    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           S = 1'b0;
    logic [W-1:0]   X = '0;
    logic [2*W-1:0] Sq;
    logic           Done;
    logic           Busy;
    logic [1:0]     State;

    int tests = 0;
    int fails = 0;

    int_square_calculator #(.W(W)) dut (
        .Clk(Clk), .Reset(Reset), .S(S), .X(X),
        .Sq(Sq), .Done(Done), .Busy(Busy), .State(State)
    );

    always #5 Clk = ~Clk;

    // Called at a negedge; raises S and counts edges (start edge included) until Done.
    task automatic run_op(input logic [W-1:0] x, output int edges, output int busy_n,
                          output bit sq_moved, output bit timed_out);
        logic [2*W-1:0] sq0;
        sq0 = Sq;
        S = 1'b1;
        X = x;
        edges = 0;
        busy_n = 0;
        sq_moved = 0;
        do begin
            @(negedge Clk);
            edges++;
            if (Busy) busy_n++;
            if (!Done && Sq !== sq0) sq_moved = 1;
        end while (!Done && edges < 1000);
        timed_out = !Done;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        S = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            tests++;
            if (Sq !== '0 || Done !== 1'b0 || Busy !== 1'b0 || State !== 2'b00) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: Sq=%0d Done=%b Busy=%b State=%b, want 0/0/0/00", i, Sq, Done, Busy, State);
            end
        end
    endtask

    task automatic test_basic();
        int e, b;
        bit m, t;
        run_op(8'd13, e, b, m, t);
        tests++;
        if (t || Sq !== 16'd169 || b != 13 || e != 14 || m) begin
            fails++;
            $display("FAIL basic13: Sq=%0d busy=%0d edges=%0d moved=%b timeout=%b, want 169/13/14/0/0", Sq, b, e, m, t);
        end
        S = 1'b0;
        @(negedge Clk);
        tests++;
        if (State !== 2'b00 || Sq !== 16'd169 || Done !== 1'b0) begin
            fails++;
            $display("FAIL basic13_release: State=%b Sq=%0d Done=%b, want 00/169/0", State, Sq, Done);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] xs [3] = '{8'd0, 8'd255, 8'd1};
        int e, b;
        bit m, t;
        for (int i = 0; i < 3; i++) begin
            run_op(xs[i], e, b, m, t);
            tests++;
            if (t || Sq !== 16'(xs[i]) * 16'(xs[i]) || b != int'(xs[i]) ||
                e != ((xs[i] == 0) ? 1 : int'(xs[i]) + 1) || m) begin
                fails++;
                $display("FAIL boundary x=%0d: Sq=%0d busy=%0d edges=%0d moved=%b timeout=%b, want Sq=%0d busy=%0d",
                         xs[i], Sq, b, e, m, t, xs[i] * xs[i], xs[i]);
            end
            S = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic test_ignore_inputs();
        S = 1'b1;
        X = 8'd20;
        @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (Busy !== 1'b1 || Done !== 1'b0) begin
                fails++;
                $display("FAIL ignore_busy cyc%0d: Busy=%b Done=%b, want 1/0", i, Busy, Done);
            end
            S = ~S;
            X = (i == 0) ? 8'd3 : W'($urandom);
            @(negedge Clk);
        end
        tests++;
        if (Done !== 1'b1 || Sq !== 16'd400) begin
            fails++;
            $display("FAIL ignore_result: Done=%b Sq=%0d, want 1/400", Done, Sq);
        end
        S = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            tests++;
            if (Done !== 1'b1 || State !== 2'b10 || Busy !== 1'b0 || Sq !== 16'd400) begin
                fails++;
                $display("FAIL hold_done cyc%0d: Done=%b State=%b Busy=%b Sq=%0d, want 1/10/0/400", i, Done, State, Busy, Sq);
            end
        end
        S = 1'b0;
        @(negedge Clk);
        tests++;
        if (State !== 2'b00) begin
            fails++;
            $display("FAIL hold_done_release: State=%b, want 00", State);
        end
    endtask

    task automatic test_reset_mid();
        int e, b;
        bit m, t;
        S = 1'b1;
        X = 8'd200;
        @(negedge Clk);
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        tests++;
        if (State !== 2'b00 || Busy !== 1'b0 || Done !== 1'b0 || Sq !== '0) begin
            fails++;
            $display("FAIL reset_mid: State=%b Busy=%b Done=%b Sq=%0d, want 00/0/0/0", State, Busy, Done, Sq);
        end
        Reset = 1'b1;
        S = 1'b0;
        @(negedge Clk);
        run_op(8'd7, e, b, m, t);
        tests++;
        if (t || Sq !== 16'd49 || b != 7 || e != 8) begin
            fails++;
            $display("FAIL after_reset x=7: Sq=%0d busy=%0d edges=%0d timeout=%b, want 49/7/8/0", Sq, b, e, t);
        end
        S = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_random();
        int e, b;
        bit m, t;
        logic [W-1:0] x;
        for (int i = 0; i < 12; i++) begin
            x = W'($urandom_range(0, 255));
            run_op(x, e, b, m, t);
            tests++;
            if (t || Sq !== 16'(x) * 16'(x) || b != int'(x) || e != ((x == 0) ? 1 : int'(x) + 1) || m) begin
                fails++;
                $display("FAIL random x=%0d: Sq=%0d busy=%0d edges=%0d moved=%b timeout=%b, want Sq=%0d", x, Sq, b, e, m, t, x * x);
            end
            S = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back();
        int e, b;
        bit m, t;
        int bad = 0;
        for (int v = 0; v < 256; v++) begin
            run_op(W'(v), e, b, m, t);
            tests++;
            if (t || Sq !== 16'(v * v) || b != v || e != ((v == 0) ? 1 : v + 1) || m) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL sweep x=%0d: Sq=%0d busy=%0d edges=%0d moved=%b timeout=%b, want Sq=%0d", v, Sq, b, e, m, t, v * v);
            end
            S = 1'b0;
            @(negedge Clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_inputs();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
